// File: rtl/spi_peripheral.sv
// Purpose: SPI mode-0 target; 16-bit frames {rw, addr[6:0], data[7:0]} write five PWM config registers.
// Latency: a register updates (with wr_pulse) SYNC_STAGES+2 clk cycles after the raw ncs rising edge.
// Backpressure: none; the SPI controller is never stalled, and malformed or invalid frames are dropped.
// Optional readback of registers on cipo is compiled in with `define SPI_READBACK_EN.
`timescale 1ns/1ps
module spi_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ncs,
    input  logic       sclk,
    input  logic       copi,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_pulse
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam int         NUM_REGS   = 5;
    localparam logic [6:0] MAX_ADDR_C = 7'(MAX_ADDR);

    // An address must be within the configured range and name one of the physical registers.
    function automatic logic addr_ok(input logic [6:0] a);
        return (a <= MAX_ADDR_C) && (a < 7'(NUM_REGS));
    endfunction

    logic [SYNC_STAGES-1:0] ncs_sync_q, sclk_sync_q, copi_sync_q;
    logic                   ncs_dly_q, sclk_dly_q;
    logic                   ncs_s, sclk_s, copi_s;
    logic                   ncs_rise, sclk_rise;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        commit_ok;
    logic [6:0]  wr_addr;
    logic [7:0]  regs_q [NUM_REGS];
    logic        wr_pulse_q;

    // Synchronize the asynchronous SPI pins and keep one extra delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync_q  <= '1;
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_dly_q   <= 1'b1;
            sclk_dly_q  <= 1'b0;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            ncs_dly_q   <= ncs_s;
            sclk_dly_q  <= sclk_s;
        end
    end

    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_rise  = ncs_s & ~ncs_dly_q;
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign wr_addr   = shift_q[14:8];

    // Frame state, bit counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // IDLE reacts to the ncs-low level so a frame starting during COMMIT is not missed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        commit_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ncs_s) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise && (cnt_q != 5'd16)) begin
                    shift_d = {shift_q[14:0], copi_s};
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            COMMIT: begin
                state_d   = IDLE;
                commit_ok = (cnt_q == 5'd16) && shift_q[15] && addr_ok(wr_addr);
            end
            default: state_d = IDLE;
        endcase
    end

    // Config registers and the write strobe update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_pulse_q <= 1'b0;
        end else begin
            if (commit_ok) regs_q[wr_addr[2:0]] <= shift_q[7:0];
            wr_pulse_q <= commit_ok;
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign wr_pulse        = wr_pulse_q;

`ifdef SPI_READBACK_EN
    logic        sclk_fall;
    logic [15:0] shift_nx;
    logic        rd_load, rd_valid;
    logic [7:0]  rd_data;
    logic [7:0]  rd_q;
    logic        cipo_q;

    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign shift_nx  = {shift_q[14:0], copi_s};
    // The 8th sampled bit completes {rw, addr}; the read value is fetched on that same edge.
    assign rd_load   = (state_q == SHIFT) && !ncs_rise && sclk_rise && (cnt_q == 5'd7);
    assign rd_valid  = !shift_nx[7] && addr_ok(shift_nx[6:0]);
    assign rd_data   = rd_valid ? regs_q[shift_nx[2:0]] : 8'h00;

    // Present bit 7 right after the address, then one bit per following sclk fall (bits 6..0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            cipo_q <= 1'b0;
        end else if (ncs_rise) begin
            rd_q   <= '0;
            cipo_q <= 1'b0;
        end else if (rd_load) begin
            cipo_q <= rd_data[7];
            rd_q   <= {rd_data[6:0], 1'b0};
        end else if ((state_q == SHIFT) && sclk_fall && (cnt_q >= 5'd9) && (cnt_q <= 5'd15)) begin
            cipo_q <= rd_q[7];
            rd_q   <= {rd_q[6:0], 1'b0};
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
`timescale 1ns/1ps
module tb_spi_peripheral;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 400;   // sclk half period: f_sclk = f_clk/8

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ncs   = 1'b1;
    logic       sclk  = 1'b0;
    logic       copi  = 1'b0;
    logic       cipo;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_pulse;

    spi_peripheral #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(4)) dut (
        .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .copi(copi), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_pulse(wr_pulse)
    );

    always #50 clk = ~clk;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    int         compared   = 0;
    int         mismatched = 0;
    int         pulses     = 0;
    int         exp_pulses = 0;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] model [5];
    logic [7:0] rd_bits;
    logic [7:0] rd_exp;

    function automatic logic [7:0] reg_out(input logic [2:0] a);
        case (a)
            3'd0:    return en_reg_out_7_0;
            3'd1:    return en_reg_out_15_8;
            3'd2:    return en_reg_pwm_7_0;
            3'd3:    return en_reg_pwm_15_8;
            3'd4:    return pwm_duty_cycle;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every wr_pulse cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && wr_pulse === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_wr_pulse", 16'(wr_pulse), 16'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_reg_value", 16'(reg_out(mon_e.addr)), 16'(mon_e.data));
            end
        end
    end

    // Drive nbits of a frame MSB first; cipo is captured just before sclk rises 9..16.
    task automatic send(input logic [15:0] f, input int nbits, input bit raise);
        ncs = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            copi = f[15-i];
            #HALF;
            if (i >= 8) rd_bits = {rd_bits[6:0], cipo};
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        copi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (raise) ncs = 1'b1;
    endtask

    task automatic expect_write(input logic [15:0] f);
        wr_t e;
        e.addr = f[10:8];
        e.data = f[7:0];
        exp_q.push_back(e);
        model[f[10:8]] = f[7:0];
        exp_pulses++;
    endtask

    task automatic write(input logic [15:0] f, input bit valid);
        if (valid) expect_write(f);
        send(f, 16, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        repeat (6) @(posedge clk);
        #1;
        for (int a = 0; a < 5; a++)
            check($sformatf("%s_reg%0d", tag, a), 16'(reg_out(3'(a))), 16'(model[a]));
        check({tag, "_pulse_count"}, 16'(pulses), 16'(exp_pulses));
        check({tag, "_queue_empty"}, 16'(exp_q.size()), 16'h0);
    endtask

    initial begin
        for (int a = 0; a < 5; a++) model[a] = 8'h00;
        rd_bits = 8'h00;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        for (int a = 0; a < 5; a++)
            check($sformatf("reset_reg%0d", a), 16'(reg_out(3'(a))), 16'h0);
        check("reset_wr_pulse", 16'(wr_pulse), 16'h0);
        check("reset_cipo", 16'(cipo), 16'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // 2: single write with exact commit latency after the raw ncs rise
        expect_write(16'h8055);
        send(16'h8055, 16, 1'b1);
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1;
        check("latency_before", 16'(en_reg_out_7_0), 16'h00);
        check("latency_pulse_before", 16'(wr_pulse), 16'h0);
        @(posedge clk);
        #1;
        check("latency_at", 16'(en_reg_out_7_0), 16'h55);
        check("latency_pulse_at", 16'(wr_pulse), 16'h1);
        check_all("write_addr0");

        // 3: back-to-back writes
        write(16'h84FF, 1'b1);
        write(16'h8280, 1'b1);
        check_all("back_to_back");

        // 4: out-of-range address and truncated frame are dropped
        write(16'h85AA, 1'b0);
        send(16'h8177, 12, 1'b1);
        repeat (3) @(posedge clk);
        check_all("dropped");

        // 5: reset in the middle of a frame, then the full frame
        send(16'h81C3, 9, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < 5; a++) model[a] = 8'h00;
        for (int a = 0; a < 5; a++)
            check($sformatf("midreset_reg%0d", a), 16'(reg_out(3'(a))), 16'h0);
        check("midreset_wr_pulse", 16'(wr_pulse), 16'h0);
        ncs  = 1'b1;
        sclk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        write(16'h81C3, 1'b1);
        check_all("after_reset");

        // 6: write then read back the same register
        write(16'h83A5, 1'b1);
        rd_bits = 8'h00;
        write(16'h0300, 1'b0);
`ifdef SPI_READBACK_EN
        rd_exp = 8'hA5;
`else
        rd_exp = 8'h00;
`endif
        check("readback_bits", 16'(rd_bits), 16'(rd_exp));
        check("cipo_idle", 16'(cipo), 16'h0);
        check_all("readback");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
